// File: rtl/expr_check_arbiter.sv
// rtl/expr_check_arbiter.sv - round-robin sharing of one expression recognizer by two byte streams; EXPR_ARB_STATS_EN adds pass/fail counters
module expr_check_arbiter #(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic [1:0] vld,
  input  logic [1:0] last,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] gnt,
  output logic       rdy,
  output logic [1:0] done,
  output logic       pass,
  output logic       chk_clr,
  output logic       chk_step,
  output logic [7:0] chk_in,
  input  logic       chk_out
`ifdef EXPR_ARB_STATS_EN
  ,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, REPORT} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LEN);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       ovf, ovf_n;
  logic       last_srv, last_srv_n;
  logic [1:0] gnt_n;
  logic       rdy_n;
  logic [1:0] done_n;
  logic       pass_n;
  logic       chk_clr_n;
  logic       chk_step_n;
  logic [7:0] chk_in_n;

  // Granted requester's view: index, request level and character lane
  logic       gsel;
  logic       greq;
  logic       gvld;
  logic       glast;
  logic [7:0] gdata;

  assign gsel  = gnt[1];
  assign greq  = req[gsel];
  assign gvld  = vld[gsel];
  assign glast = last[gsel];
  assign gdata = gsel ? data1 : data0;

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and next values of every registered output
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ovf_n      = ovf;
    last_srv_n = last_srv;
    gnt_n      = gnt;
    rdy_n      = rdy;
    done_n     = 2'b00;
    pass_n     = 1'b0;
    chk_clr_n  = 1'b0;
    chk_step_n = 1'b0;
    chk_in_n   = chk_in;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          // On a tie the requester not served last wins
          if (req == 2'b11) gnt_n = last_srv ? 2'b01 : 2'b10;
          else              gnt_n = req;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        if (!greq) begin
          gnt_n   = 2'b00;
          state_n = IDLE;
        end else begin
          chk_clr_n = 1'b1;
          cnt_n     = 8'd0;
          ovf_n     = 1'b0;
          state_n   = FEED;
        end
      end
      FEED: begin
        // rdy rises one cycle into FEED, so the clear lands before any step
        if (!greq) begin
          gnt_n   = 2'b00;
          rdy_n   = 1'b0;
          state_n = IDLE;
        end else if (rdy && gvld) begin
          chk_step_n = 1'b1;
          chk_in_n   = gdata;
          cnt_n      = cnt + 8'd1;
          if (glast) begin
            rdy_n   = 1'b0;
            state_n = WAIT;
          end else if (cnt + 8'd1 == MAX_CNT) begin
            ovf_n   = 1'b1;
            rdy_n   = 1'b0;
            state_n = WAIT;
          end
        end else begin
          rdy_n = 1'b1;
        end
      end
      WAIT: begin
        state_n = REPORT;
      end
      REPORT: begin
        done_n     = gnt;
        pass_n     = chk_out & ~ovf;
        gnt_n      = 2'b00;
        last_srv_n = gsel;
        state_n    = IDLE;
      end
      default: begin
        gnt_n   = 2'b00;
        rdy_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // Registered outputs and transaction bookkeeping
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt      <= 8'd0;
      ovf      <= 1'b0;
      last_srv <= 1'b1;
      gnt      <= 2'b00;
      rdy      <= 1'b0;
      done     <= 2'b00;
      pass     <= 1'b0;
      chk_clr  <= 1'b0;
      chk_step <= 1'b0;
      chk_in   <= 8'd0;
    end else begin
      cnt      <= cnt_n;
      ovf      <= ovf_n;
      last_srv <= last_srv_n;
      gnt      <= gnt_n;
      rdy      <= rdy_n;
      done     <= done_n;
      pass     <= pass_n;
      chk_clr  <= chk_clr_n;
      chk_step <= chk_step_n;
      chk_in   <= chk_in_n;
    end
  end

`ifdef EXPR_ARB_STATS_EN
  // Saturating verdict counters, one bump per completed transaction
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pass_cnt <= 16'd0;
      fail_cnt <= 16'd0;
    end else if (state == REPORT) begin
      if (pass_n) begin
        if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
      end else begin
        if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_expr_check_arbiter.sv
// tb/tb_expr_check_arbiter.sv - scoreboard bench for expr_check_arbiter with a recognizer model
module tb_expr_check_arbiter;

  typedef struct packed {
    logic [1:0] d;
    logic       p;
    logic [7:0] lat;
  } done_exp_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] vld = 2'b00;
  logic [1:0] last = 2'b00;
  logic [7:0] data0 = 8'd0;
  logic [7:0] data1 = 8'd0;
  logic [1:0] gnt;
  logic       rdy;
  logic [1:0] done;
  logic       pass;
  logic       chk_clr;
  logic       chk_step;
  logic [7:0] chk_in;
  logic       chk_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  int clr_pulses = 0;
  logic [1:0] prev_gnt = 2'b00;
  logic prev_chk_clr = 1'b0;

  done_exp_t  exp_done_q[$];
  logic [7:0] exp_step_q[$];
  logic [1:0] exp_gnt_q[$];

  expr_check_arbiter #(.MAX_LEN(4)) dut (
    .clk(clk), .clr(clr), .req(req), .vld(vld), .last(last),
    .data0(data0), .data1(data1), .gnt(gnt), .rdy(rdy), .done(done),
    .pass(pass), .chk_clr(chk_clr), .chk_step(chk_step), .chk_in(chk_in),
    .chk_out(chk_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Recognizer model: 0 start, 1 after digit (accepting), 2 after operator, 3 error
  logic [1:0] rs;
  assign chk_out = (rs == 2'd1);
  always @(posedge clk or posedge clr) begin
    if (clr) rs <= 2'd0;
    else if (chk_clr) rs <= 2'd0;
    else if (chk_step) begin
      if (chk_in >= 8'd48 && chk_in <= 8'd57) rs <= (rs == 2'd0 || rs == 2'd2) ? 2'd1 : 2'd3;
      else if (chk_in == 8'd42 || chk_in == 8'd43) rs <= (rs == 2'd1) ? 2'd2 : 2'd3;
      else rs <= 2'd3;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input int act);
    tests++;
    fails++;
    $display("FAIL %s: got %0d expected none", name, act);
  endtask

  // Monitor: pops expectations whenever the DUT presents grant, step or done
  always @(negedge clk) begin
    if (!clr) begin
      if (gnt != 2'b00 && prev_gnt == 2'b00) begin
        gnt_cyc = cyc;
        if (exp_gnt_q.size() == 0) note_fail("unexpected_gnt", int'(gnt));
        else chk("gnt_order", int'(gnt), int'(exp_gnt_q.pop_front()));
      end
      if (chk_step) begin
        if (exp_step_q.size() == 0) note_fail("unexpected_step", int'(chk_in));
        else chk("chk_in", int'(chk_in), int'(exp_step_q.pop_front()));
      end
      if (chk_clr) begin
        clr_pulses++;
        if (prev_chk_clr) note_fail("chk_clr_width", 2);
      end
      if (done != 2'b00) begin
        if (exp_done_q.size() == 0) note_fail("unexpected_done", int'(done));
        else begin
          done_exp_t e;
          e = exp_done_q.pop_front();
          chk("done", int'(done), int'(e.d));
          chk("pass", int'(pass), int'(e.p));
          chk("latency", cyc - gnt_cyc, int'(e.lat));
        end
      end else if (pass) begin
        note_fail("pass_without_done", 1);
      end
      prev_gnt     = gnt;
      prev_chk_clr = chk_clr;
    end else begin
      prev_gnt     = 2'b00;
      prev_chk_clr = 1'b0;
    end
  end

  task automatic push_done(input logic [1:0] d, input logic p, input int lat);
    done_exp_t e;
    e.d = d;
    e.p = p;
    e.lat = 8'(lat);
    exp_done_q.push_back(e);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_step_q.push_back(s[i]);
  endtask

  task automatic drive(input int r, input logic v, input logic l, input logic [7:0] d);
    vld[r[0]]  = v;
    last[r[0]] = l;
    if (r == 0) data0 = d;
    else        data1 = d;
  endtask

  // Called at a negedge; returns at the negedge after the character is taken
  task automatic send_char(input int r, input logic [7:0] d, input logic l);
    drive(r, 1'b1, l, d);
    for (int k = 0; k < 60; k++) begin
      if (rdy && gnt[r[0]]) begin
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    note_fail("accept_timeout", r);
  endtask

  task automatic wait_done(input int r);
    for (int k = 0; k < 60; k++) begin
      if (done[r[0]]) return;
      @(negedge clk);
    end
    note_fail("done_timeout", r);
  endtask

  task automatic txn(input int r, input string s, input bit hold);
    req[r[0]] = 1'b1;
    for (int i = 0; i < s.len(); i++) send_char(r, s[i], (i == s.len() - 1));
    drive(r, 1'b0, 1'b0, 8'd0);
    wait_done(r);
    if (!hold) req[r[0]] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    // Reset values, with both requests already held
    req = 2'b11;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_rdy", int'(rdy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_chk_clr", int'(chk_clr), 0);
    chk("rst_chk_step", int'(chk_step), 0);
    chk("rst_chk_in", int'(chk_in), 0);
    repeat (3) @(negedge clk);

    // Round robin with both requests held from reset
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b01);
    push_str("555");
    push_done(2'b01, 1'b1, 5); push_done(2'b10, 1'b1, 5); push_done(2'b01, 1'b1, 5);
    clr = 1'b0;
    fork
      begin txn(0, "5", 1'b1); txn(0, "5", 1'b0); end
      begin txn(1, "5", 1'b0); end
    join
    repeat (3) @(negedge clk);

    // Requester 0: "1+2" passes, one clear pulse
    c0 = clr_pulses;
    exp_gnt_q.push_back(2'b01);
    push_str("1+2");
    push_done(2'b01, 1'b1, 7);
    txn(0, "1+2", 1'b0);
    chk("clr_pulses_t1", clr_pulses - c0, 1);
    repeat (2) @(negedge clk);

    // Requester 1: "12" then "7*", both fail
    exp_gnt_q.push_back(2'b10); exp_gnt_q.push_back(2'b10);
    push_str("127*");
    push_done(2'b10, 1'b0, 6); push_done(2'b10, 1'b0, 6);
    txn(1, "12", 1'b0);
    txn(1, "7*", 1'b0);
    repeat (2) @(negedge clk);

    // Length limit: the 4th character without last closes the transaction
    exp_gnt_q.push_back(2'b01);
    push_str("1+2+");
    push_done(2'b01, 1'b0, 8);
    req[0] = 1'b1;
    send_char(0, "1", 1'b0);
    send_char(0, "+", 1'b0);
    send_char(0, "2", 1'b0);
    send_char(0, "+", 1'b0);
    drive(0, 1'b1, 1'b0, "3");
    wait_done(0);
    chk("ovf_rdy_low", int'(rdy), 0);
    req[0] = 1'b0;
    drive(0, 1'b0, 1'b0, 8'd0);
    repeat (3) @(negedge clk);

    // Abandon after one character, then requester 1 sends "9"
    exp_gnt_q.push_back(2'b01);
    push_str("1");
    req[0] = 1'b1;
    send_char(0, "1", 1'b0);
    drive(0, 1'b0, 1'b0, 8'd0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("abandon_gnt", int'(gnt), 0);
    chk("abandon_rdy", int'(rdy), 0);
    exp_gnt_q.push_back(2'b10);
    push_str("9");
    push_done(2'b10, 1'b1, 5);
    txn(1, "9", 1'b0);
    repeat (2) @(negedge clk);

    // Asynchronous clear in the middle of FEED
    exp_gnt_q.push_back(2'b01);
    push_str("1");
    req[0] = 1'b1;
    send_char(0, "1", 1'b0);
    drive(0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr_gnt", int'(gnt), 0);
    chk("clr_rdy", int'(rdy), 0);
    chk("clr_done", int'(done), 0);
    chk("clr_chk_in", int'(chk_in), 0);
    chk("clr_chk_step", int'(chk_step), 0);
    req[0] = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    exp_gnt_q.push_back(2'b01);
    push_str("3*4");
    push_done(2'b01, 1'b1, 7);
    txn(0, "3*4", 1'b0);

    repeat (10) @(negedge clk);
    chk("left_done", exp_done_q.size(), 0);
    chk("left_step", exp_step_q.size(), 0);
    chk("left_gnt", exp_gnt_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
